// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 8N1-style deserialiser with valid/ready output and error pulses
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_in,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int BW               = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // Counters are loaded with N-1 so that the zero cycle lands exactly N cycles later.
  localparam logic [31:0]   PULSE_RELOAD = 32'(PULSE_WIDTH - 1);
  localparam logic [31:0]   HALF_RELOAD  = 32'(HALF_PULSE_WIDTH - 1);
  localparam logic [BW-1:0] LAST_BIT     = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [1:0]            sync_q;
  logic                  rx_s;
  logic                  word_done;
  logic                  stop_bad;

  assign rx_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous line; resets to the idle (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_in};
    end
  end

  // Receive FSM state, bit-period counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: each sample point is reached when the down-counter hits zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = HALF_RELOAD;
        end
      end
      S_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
          cnt_d   = PULSE_RELOAD;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
          cnt_d   = PULSE_RELOAD;
          if (bit_q == LAST_BIT) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (rx_s) begin
          word_done = 1'b1;
          state_d   = S_IDLE;
        end else begin
          stop_bad = 1'b1;
          state_d  = S_BREAK;
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register: load, replace-on-accept, or drop with overrun; clear on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (word_done) begin
        if (!valid || ready) begin
          data  <= shift_q;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

  localparam int BIT_CYC = 10;
  localparam int LATENCY = 98;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_in = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;

  logic [7:0] acc_q[$];
  int         rise_q[$];
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         ovr_cyc = -1;
  int         vcnt = 0;
  logic       valid_prev = 1'b0;

  uart_rx #(
    .DATA_WIDTH(8),
    .BAUD_RATE(100_000),
    .CLK_FREQ(1_000_000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .uart_in(uart_in),
    .data(data),
    .valid(valid),
    .ready(ready),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid && !valid_prev) rise_q.push_back(cyc);
      if (valid) vcnt++;
      if (valid && ready) acc_q.push_back(data);
      if (frame_err) ferr_cnt++;
      if (overrun) begin
        ovr_cnt++;
        ovr_cyc = cyc;
      end
    end
    valid_prev = valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    acc_q.delete();
    rise_q.delete();
    ferr_cnt = 0;
    ovr_cnt  = 0;
    ovr_cyc  = -1;
    vcnt     = 0;
  endtask

  task automatic drive_bit(input logic b);
    uart_in = b;
    repeat (BIT_CYC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop_ok;
    int         brk;
    int         exp_words;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_q[$];
  int         expf_q[$];
  int         nbad;
  int         f2;
  logic [7:0] rd;
  logic       rok;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 0,   1, 8'hA5, 0};
    vecs[1] = '{8'h00, 1'b1, 0,   1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 0,   1, 8'hFF, 0};
    vecs[3] = '{8'h55, 1'b0, 200, 0, 8'h00, 1};
    vecs[4] = '{8'h81, 1'b1, 0,   1, 8'h81, 0};
    vecs[5] = '{8'h3C, 1'b0, 0,   0, 8'h00, 1};

    repeat (3) tick();
    check("reset_data", 32'(data), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    repeat (5) tick();

    // Table: single frames with ready held high
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      send_frame(vecs[i].d, vecs[i].stop_ok);
      repeat (vecs[i].brk) tick();
      uart_in = 1'b1;
      repeat (20) tick();
      check($sformatf("tbl%0d_words", i), 32'(acc_q.size()), 32'(vecs[i].exp_words));
      check($sformatf("tbl%0d_valid_cycles", i), 32'(vcnt), 32'(vecs[i].exp_words));
      check($sformatf("tbl%0d_frame_err", i), 32'(ferr_cnt), 32'(vecs[i].exp_ferr));
      check($sformatf("tbl%0d_overrun", i), 32'(ovr_cnt), 32'h0);
      if (vecs[i].exp_words == 1) begin
        check($sformatf("tbl%0d_data", i), 32'(acc_q.size() > 0 ? acc_q[0] : 8'hxx), 32'(vecs[i].exp_data));
        check($sformatf("tbl%0d_latency", i), 32'(rise_q.size() > 0 ? rise_q[0] - fall_cyc : -1), 32'(LATENCY));
      end
    end

    // False start followed by a real frame
    clear_mon();
    uart_in = 1'b0;
    repeat (3) tick();
    uart_in = 1'b1;
    repeat (20) tick();
    check("false_start_valid", 32'(vcnt), 32'h0);
    check("false_start_ferr", 32'(ferr_cnt), 32'h0);
    send_frame(8'h3C, 1'b1);
    repeat (10) tick();
    check("after_false_words", 32'(acc_q.size()), 32'h1);
    check("after_false_data", 32'(acc_q.size() > 0 ? acc_q[0] : 8'hxx), 32'h3C);
    check("after_false_latency", 32'(rise_q.size() > 0 ? rise_q[0] - fall_cyc : -1), 32'(LATENCY));

    // Backpressure: second back-to-back word dropped with one overrun pulse
    clear_mon();
    ready = 1'b0;
    send_frame(8'h12, 1'b1);
    f2 = cyc;
    send_frame(8'h34, 1'b1);
    repeat (5) tick();
    check("bp_valid", 32'(valid), 32'h1);
    check("bp_data", 32'(data), 32'h12);
    check("bp_overrun_count", 32'(ovr_cnt), 32'h1);
    check("bp_overrun_cycle", 32'(ovr_cyc), 32'(f2 + LATENCY));
    check("bp_no_accept", 32'(acc_q.size()), 32'h0);
    ready = 1'b1;
    tick();
    check("bp_valid_drop", 32'(valid), 32'h0);
    check("bp_data_kept", 32'(data), 32'h12);
    check("bp_accepted", 32'(acc_q.size() > 0 ? acc_q[0] : 8'hxx), 32'h12);

    // Accept in the same cycle as the next stop sample
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    repeat (5) tick();
    clear_mon();
    f2 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'((8'h22 >> i) & 8'h01));
    uart_in = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("sim_stop_cycle", 32'(cyc), 32'(f2 + LATENCY - 1));
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("sim_valid", 32'(valid), 32'h1);
    check("sim_data", 32'(data), 32'h22);
    check("sim_overrun", 32'(ovr_cnt), 32'h0);
    check("sim_consumed_old", 32'(acc_q.size() > 0 ? acc_q[0] : 8'hxx), 32'h11);
    repeat (3) tick();
    ready = 1'b1;
    repeat (3) tick();

    // Reset in the middle of bit 4 of 0xF0
    clear_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    uart_in = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_data", 32'(data), 32'h0);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_ferr", 32'(frame_err), 32'h0);
    check("mid_rst_ovr", 32'(overrun), 32'h0);
    rst = 1'b0;
    repeat (50) tick();
    clear_mon();
    send_frame(8'h0F, 1'b1);
    repeat (10) tick();
    check("post_rst_words", 32'(acc_q.size()), 32'h1);
    check("post_rst_data", 32'(acc_q.size() > 0 ? acc_q[0] : 8'hxx), 32'h0F);
    check("post_rst_latency", 32'(rise_q.size() > 0 ? rise_q[0] - fall_cyc : -1), 32'(LATENCY));
    check("post_rst_pulses", 32'(ferr_cnt + ovr_cnt), 32'h0);

    // Random frames, glitches and framing errors against a word-level model
    clear_mon();
    nbad = 0;
    for (int n = 0; n < 12; n++) begin
      rd  = 8'($urandom);
      rok = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        uart_in = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        uart_in = 1'b1;
        repeat (8) tick();
      end
      send_frame(rd, rok);
      if (rok) begin
        exp_q.push_back(rd);
        expf_q.push_back(fall_cyc);
      end else begin
        nbad++;
        repeat ($urandom_range(0, 30)) tick();
      end
      uart_in = 1'b1;
      repeat ($urandom_range(1, 12)) tick();
    end
    repeat (20) tick();
    check("rnd_words", 32'(acc_q.size()), 32'(exp_q.size()));
    check("rnd_rises", 32'(rise_q.size()), 32'(exp_q.size()));
    check("rnd_frame_err", 32'(ferr_cnt), 32'(nbad));
    check("rnd_overrun", 32'(ovr_cnt), 32'h0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < acc_q.size()) check($sformatf("rnd%0d_data", i), 32'(acc_q[i]), 32'(exp_q[i]));
      if (i < rise_q.size()) check($sformatf("rnd%0d_latency", i), 32'(rise_q[i] - expf_q[i]), 32'(LATENCY));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
